// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage: IF/ID payload, fetch action
// decode and the word-alignment helper used on redirect targets.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  typedef enum logic [1:0] {
    FETCH_ADVANCE = 2'd0,
    FETCH_HOLD    = 2'd1,
    FETCH_FLUSH   = 2'd2
  } fetch_action_t;

  // Redirect beats stall: a flush must never be swallowed by a hold.
  function automatic fetch_action_t decode_action(input logic stall,
                                                  input logic redirect_valid);
    fetch_action_t act;
    if (redirect_valid) begin
      act = FETCH_FLUSH;
    end else if (stall) begin
      act = FETCH_HOLD;
    end else begin
      act = FETCH_ADVANCE;
    end
    return act;
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/EX control in, instruction-memory port, IF/ID
// outputs. Optional perf counters appear with FETCH_PERF_CNT_EN.
interface fetch_if;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_if;
  logic [31:0] pc_out;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  instr_if,
    output pc_out,
    output ifid_pc,
    output ifid_pc_plus4,
    output ifid_instr,
`ifdef FETCH_PERF_CNT_EN
    output perf_fetched,
    output perf_stall_cycles,
    output perf_flushes,
`endif
    output ifid_valid
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_target,
    output instr_if,
    input  pc_out,
    input  ifid_pc,
    input  ifid_pc_plus4,
    input  ifid_instr,
`ifdef FETCH_PERF_CNT_EN
    input  perf_fetched,
    input  perf_stall_cycles,
    input  perf_flushes,
`endif
    input  ifid_valid
  );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// Generic pipeline register for the IF/ID payload: advance, hold or flush
// to a bubble, as selected by a fetch_action_t.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic          clk,
  input  logic          resetn,
  input  fetch_action_t action,
  input  ifid_t         d,
  output ifid_t         q
);

  ifid_t bubble_s;
  ifid_t q_next_s;
  ifid_t q_r;

  // Bubble payload: zero PCs, NOP encoding, not valid.
  always_comb begin
    bubble_s          = '0;
    bubble_s.instr    = BUBBLE_INSTR;
    bubble_s.valid    = 1'b0;
  end

  // Next-state selection from the decoded action.
  always_comb begin
    q_next_s = q_r;
    case (action)
      FETCH_ADVANCE: q_next_s = d;
      FETCH_HOLD:    q_next_s = q_r;
      FETCH_FLUSH:   q_next_s = bubble_s;
      default:       q_next_s = bubble_s;
    endcase
  end

  // Payload register, bubble on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_r <= bubble_s;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives instr_mem, and registers the fetched word into
// IF/ID. Define FETCH_PERF_CNT_EN to add fetch/stall/flush counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic    clk,
  input  logic    resetn,
  fetch_if.master bus
);

  import fetch_pkg::*;

  fetch_action_t action_s;
  logic [31:0]   pc_r;
  logic [31:0]   pc_next_s;
  logic [31:0]   pc_plus4_s;
  ifid_t         ifid_d_s;
  ifid_t         ifid_q_s;

  assign action_s   = decode_action(bus.stall, bus.redirect_valid);
  assign pc_plus4_s = pc_r + PC_STEP;

  // Next fetch address; redirect targets are forced word aligned.
  always_comb begin
    pc_next_s = pc_r;
    case (action_s)
      FETCH_ADVANCE: pc_next_s = pc_plus4_s;
      FETCH_HOLD:    pc_next_s = pc_r;
      FETCH_FLUSH:   pc_next_s = align_word(bus.redirect_target);
      default:       pc_next_s = pc_r;
    endcase
  end

  // Program counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // Word currently being fetched, as it would land in IF/ID.
  always_comb begin
    ifid_d_s          = '0;
    ifid_d_s.pc       = pc_r;
    ifid_d_s.pc_plus4 = pc_plus4_s;
    ifid_d_s.instr    = bus.instr_if;
    ifid_d_s.valid    = 1'b1;
  end

  ifid_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk    (clk),
    .resetn (resetn),
    .action (action_s),
    .d      (ifid_d_s),
    .q      (ifid_q_s)
  );

  assign bus.pc_out        = pc_r;
  assign bus.ifid_pc       = ifid_q_s.pc;
  assign bus.ifid_pc_plus4 = ifid_q_s.pc_plus4;
  assign bus.ifid_instr    = ifid_q_s.instr;
  assign bus.ifid_valid    = ifid_q_s.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_stall_cycles_r;
  logic [31:0] perf_flushes_r;

  // Event counters, one per fetch action, wrapping silently.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetched_r      <= 32'h0000_0000;
      perf_stall_cycles_r <= 32'h0000_0000;
      perf_flushes_r      <= 32'h0000_0000;
    end else begin
      case (action_s)
        FETCH_ADVANCE: perf_fetched_r      <= perf_fetched_r + 32'h0000_0001;
        FETCH_HOLD:    perf_stall_cycles_r <= perf_stall_cycles_r + 32'h0000_0001;
        FETCH_FLUSH:   perf_flushes_r      <= perf_flushes_r + 32'h0000_0001;
        default:       perf_fetched_r      <= perf_fetched_r;
      endcase
    end
  end

  assign bus.perf_fetched      = perf_fetched_r;
  assign bus.perf_stall_cycles = perf_stall_cycles_r;
  assign bus.perf_flushes      = perf_flushes_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a cycle-level
// reference model of the IF stage rules.
module tb_fetch_stage;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  logic [31:0] m_ipc4;
  logic [31:0] m_instr;
  logic        m_valid;
  int unsigned m_fetched;
  int unsigned m_stalls;
  int unsigned m_flushes;

  fetch_if bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0000_0000: w = 32'h0010_0513;
      32'h0000_0004: w = 32'h0020_0593;
      32'h0000_0008: w = 32'h0030_0613;
      default:       w = (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endcase
    return w;
  endfunction

  assign bus.instr_if = mem_word(bus.pc_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".pc_out"},        bus.pc_out,        m_pc);
    check({ctx, ".ifid_pc"},       bus.ifid_pc,       m_ipc);
    check({ctx, ".ifid_pc_plus4"}, bus.ifid_pc_plus4, m_ipc4);
    check({ctx, ".ifid_instr"},    bus.ifid_instr,    m_instr);
    check({ctx, ".ifid_valid"},    {31'd0, bus.ifid_valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    check({ctx, ".perf_fetched"},      bus.perf_fetched,      m_fetched);
    check({ctx, ".perf_stall_cycles"}, bus.perf_stall_cycles, m_stalls);
    check({ctx, ".perf_flushes"},      bus.perf_flushes,      m_flushes);
`endif
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    m_instr = 32'h0000_0013; m_valid = 1'b0;
    m_fetched = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // Called away from clock edges; leaves time just after the next negedge.
  task automatic step(input string ctx, input logic s, input logic rv, input logic [31:0] tgt);
    bus.stall = s; bus.redirect_valid = rv; bus.redirect_target = tgt;
    if (rv) begin
      m_pc = {tgt[31:2], 2'b00};
      m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = 32'h0000_0013; m_valid = 1'b0;
      m_flushes++;
    end else if (s) begin
      m_stalls++;
    end else begin
      m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = mem_word(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      m_fetched++;
    end
    @(posedge clk);
    #1;
    check_all(ctx);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Free-running fetch from 0
    step("run0", 1'b0, 1'b0, 32'h0);
    check("run0.instr_lit", bus.ifid_instr, 32'h0010_0513);
    step("run1", 1'b0, 1'b0, 32'h0);
    check("run1.pc_lit", bus.pc_out, 32'h0000_0008);
    // Stall two cycles at pc 8, then release
    step("stall0", 1'b1, 1'b0, 32'h0);
    step("stall1", 1'b1, 1'b0, 32'h0);
    check("stall1.ipc_lit", bus.ifid_pc, 32'h0000_0004);
    step("resume", 1'b0, 1'b0, 32'h0);
    check("resume.pc_lit", bus.pc_out, 32'h0000_000C);
    // Redirect to 0x40
    step("redir", 1'b0, 1'b1, 32'h0000_0040);
    check("redir.instr_lit", bus.ifid_instr, 32'h0000_0013);
    step("after_redir", 1'b0, 1'b0, 32'h0);
    check("after_redir.ipc_lit", bus.ifid_pc, 32'h0000_0040);
    // Redirect with stall, unaligned target
    step("redir_stall", 1'b1, 1'b1, 32'h0000_0023);
    check("redir_stall.pc_lit", bus.pc_out, 32'h0000_0020);
    // Async reset between edges at pc 0x40
    step("redir40", 1'b0, 1'b1, 32'h0000_0040);
    #1 resetn = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    #1 resetn = 1'b1;
    step("post_reset0", 1'b0, 1'b0, 32'h0);
    step("post_reset1", 1'b0, 1'b0, 32'h0);
    // PC wrap at top of address space
    step("redir_top", 1'b0, 1'b1, 32'hFFFF_FFFE);
    step("wrap", 1'b0, 1'b0, 32'h0);
    check("wrap.pc4_lit", bus.ifid_pc_plus4, 32'h0000_0000);
    // Back-to-back redirects
    step("redir_a", 1'b0, 1'b1, 32'h0000_1000);
    step("redir_b", 1'b0, 1'b1, 32'h0000_2005);
    step("after_ab", 1'b0, 1'b0, 32'h0);

    // Randomized mix of fetch, stall and redirect
    for (int i = 0; i < 300; i++) begin
      logic rs;
      logic rr;
      rs = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 7) == 0);
      step("rand", rs, rr, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
